sq_age_search: RTL and testbench

- Store queue for the LSQ. Circular buffer of SQ_SIZE store entries.
- Allocates entries at dispatch, fills address and data at execute, and drains the head to the D-cache write port at retire.
- Provides a combinational load-lookup port that produces an unrotated, age-masked match vector plus the rotate amount.
- The downstream circular left barrel shifter uses these to put the head at bit 0 for youngest-older-store selection.

---
 rtl/sq_age_search_pkg.sv | 25 ++
 rtl/sq_age_search_age_mask.sv | 23 ++
 rtl/sq_age_search.sv | 172 +++++++++++++++++
 tb/tb_sq_age_search.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sq_age_search_pkg.sv
// Shared types for the store queue: entry record and memory access size encoding.
`ifndef SQ_SIZE
`define SQ_SIZE 8
`endif

package sq_age_search_pkg;

  localparam int SQ_DEFAULT_SIZE = `SQ_SIZE;
  localparam int SQ_XLEN         = 32;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic               valid;
    logic               resolved;
    logic [SQ_XLEN-1:0] addr;
    logic [SQ_XLEN-1:0] data;
    mem_size_t          size;
  } sq_entry_t;

endpackage

// File: rtl/sq_age_search_age_mask.sv
// Circular [head, tail) range mask; an equal head and tail yields an empty range.
module sq_age_mask #(
  parameter int SQ_SIZE = 8,
  parameter int IDXW    = $clog2(SQ_SIZE)
) (
  input  logic [IDXW-1:0]    head,
  input  logic [IDXW-1:0]    tail,
  output logic [SQ_SIZE-1:0] mask
);

  logic [IDXW-1:0] span;

  assign span = tail - head;

  // An entry is inside the range when its distance from head is below the span.
  always_comb begin
    mask = '0;
    for (int i = 0; i < SQ_SIZE; i++) begin
      mask[i] = (IDXW'(IDXW'(i) - head) < span);
    end
  end

endmodule

// File: rtl/sq_age_search.sv
// Store queue: circular buffer with dispatch/execute/commit/squash and an
// unrotated age-masked load lookup for a downstream head-aligning shifter.
module sq_age_search
  import sq_age_search_pkg::*;
#(
  parameter int SQ_SIZE = SQ_DEFAULT_SIZE,
  parameter int XLEN    = SQ_XLEN,
  parameter int IDXW    = $clog2(SQ_SIZE)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               disp_en,
  output logic [IDXW-1:0]    disp_idx,
  output logic               full,
  output logic               empty,
  input  logic               ex_en,
  input  logic [IDXW-1:0]    ex_idx,
  input  logic [XLEN-1:0]    ex_addr,
  input  logic [XLEN-1:0]    ex_data,
  input  logic [1:0]         ex_size,
  input  logic               commit_en,
  output logic               head_ready,
  output logic               mem_wr_valid,
  output logic [XLEN-1:0]    mem_wr_addr,
  output logic [XLEN-1:0]    mem_wr_data,
  output logic [1:0]         mem_wr_size,
  input  logic               squash_en,
  input  logic               ld_en,
  input  logic [XLEN-1:0]    ld_addr,
  input  logic [IDXW-1:0]    ld_tail,
  output logic [SQ_SIZE-1:0] ld_match_vec,
  output logic               ld_unresolved,
  output logic [IDXW-1:0]    ld_rot_amt,
  output logic [IDXW-1:0]    head_idx
);

  sq_entry_t         entries_q [SQ_SIZE];
  sq_entry_t         entries_d [SQ_SIZE];
  logic [IDXW-1:0]   head_q, head_d;
  logic [IDXW-1:0]   tail_q, tail_d;
  logic [IDXW:0]     count_q, count_d;
  logic              mem_wr_valid_q, mem_wr_valid_d;
  logic [XLEN-1:0]   mem_wr_addr_q, mem_wr_addr_d;
  logic [XLEN-1:0]   mem_wr_data_q, mem_wr_data_d;
  mem_size_t         mem_wr_size_q, mem_wr_size_d;

  logic              disp_fire;
  logic              ex_fire;
  logic              commit_fire;
  logic [SQ_SIZE-1:0] age_mask;
  logic [SQ_SIZE-1:0] valid_vec;
  logic [SQ_SIZE-1:0] resolved_vec;
  logic [SQ_SIZE-1:0] addr_hit;
  logic [SQ_SIZE-1:0] older;
  logic [1:0]         ld_addr_lo_unused;

  assign full       = (count_q == (IDXW+1)'(SQ_SIZE));
  assign empty      = (count_q == '0);
  assign disp_idx   = tail_q;
  assign head_idx   = head_q;
  assign head_ready = entries_q[head_q].valid && entries_q[head_q].resolved;

  // Handshake: commit_en is accepted only in a cycle where head_ready is high;
  // mem_wr_valid is a single-cycle strobe with no backpressure from the cache.
  assign commit_fire = commit_en && head_ready;
  assign disp_fire   = disp_en && !full && !squash_en;
  assign ex_fire     = ex_en && entries_q[ex_idx].valid && !squash_en;

  always_comb begin
    entries_d      = entries_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    mem_wr_valid_d = 1'b0;
    mem_wr_addr_d  = mem_wr_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
    mem_wr_size_d  = mem_wr_size_q;

    if (commit_fire) begin
      mem_wr_valid_d = 1'b1;
      mem_wr_addr_d  = entries_q[head_q].addr;
      mem_wr_data_d  = entries_q[head_q].data;
      mem_wr_size_d  = entries_q[head_q].size;
      head_d         = head_q + IDXW'(1);
    end

    if (squash_en) begin
      for (int i = 0; i < SQ_SIZE; i++) begin
        entries_d[i].valid    = 1'b0;
        entries_d[i].resolved = 1'b0;
      end
      tail_d  = head_d;
      count_d = '0;
    end else begin
      if (ex_fire) begin
        entries_d[ex_idx].addr     = ex_addr;
        entries_d[ex_idx].data     = ex_data;
        entries_d[ex_idx].size     = mem_size_t'(ex_size);
        entries_d[ex_idx].resolved = 1'b1;
      end
      if (disp_fire) begin
        entries_d[tail_q].valid    = 1'b1;
        entries_d[tail_q].resolved = 1'b0;
        tail_d                     = tail_q + IDXW'(1);
      end
      // Retire clears the head last so a same-cycle execute cannot revive it.
      if (commit_fire) begin
        entries_d[head_q].valid    = 1'b0;
        entries_d[head_q].resolved = 1'b0;
      end
      count_d = count_q + (IDXW+1)'(disp_fire) - (IDXW+1)'(commit_fire);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SQ_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      mem_wr_valid_q <= 1'b0;
      mem_wr_addr_q  <= '0;
      mem_wr_data_q  <= '0;
      mem_wr_size_q  <= BYTE;
    end else begin
      entries_q      <= entries_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      mem_wr_valid_q <= mem_wr_valid_d;
      mem_wr_addr_q  <= mem_wr_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      mem_wr_size_q  <= mem_wr_size_d;
    end
  end

  assign mem_wr_valid = mem_wr_valid_q;
  assign mem_wr_addr  = mem_wr_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign mem_wr_size  = mem_wr_size_q;

  sq_age_mask #(
    .SQ_SIZE (SQ_SIZE),
    .IDXW    (IDXW)
  ) u_age_mask (
    .head (head_q),
    .tail (ld_tail),
    .mask (age_mask)
  );

  // Byte offset is ignored: matching is at word granularity.
  assign ld_addr_lo_unused = ld_addr[1:0];

  always_comb begin
    valid_vec    = '0;
    resolved_vec = '0;
    addr_hit     = '0;
    for (int i = 0; i < SQ_SIZE; i++) begin
      valid_vec[i]    = entries_q[i].valid;
      resolved_vec[i] = entries_q[i].resolved;
      addr_hit[i]     = (entries_q[i].addr[XLEN-1:2] == ld_addr[XLEN-1:2]);
    end
  end

  assign older         = valid_vec & age_mask;
  assign ld_match_vec  = ld_en ? (older & resolved_vec & addr_hit) : '0;
  assign ld_unresolved = ld_en ? |(older & ~resolved_vec) : 1'b0;
  assign ld_rot_amt    = ld_en ? (IDXW'(0) - head_q) : '0;

endmodule

// File: tb/tb_sq_age_search.sv
// Bench for sq_age_search: directed scenarios plus randomized traffic, all
// outputs compared every cycle against an array/queue model of the store queue.
module tb_sq_age_search;

  localparam int N    = 8;
  localparam int IDXW = 3;
  localparam int XLEN = 32;
  localparam int W    = 66;

  logic            clock;
  logic            reset;
  logic            disp_en;
  logic [IDXW-1:0] disp_idx;
  logic            full;
  logic            empty;
  logic            ex_en;
  logic [IDXW-1:0] ex_idx;
  logic [XLEN-1:0] ex_addr;
  logic [XLEN-1:0] ex_data;
  logic [1:0]      ex_size;
  logic            commit_en;
  logic            head_ready;
  logic            mem_wr_valid;
  logic [XLEN-1:0] mem_wr_addr;
  logic [XLEN-1:0] mem_wr_data;
  logic [1:0]      mem_wr_size;
  logic            squash_en;
  logic            ld_en;
  logic [XLEN-1:0] ld_addr;
  logic [IDXW-1:0] ld_tail;
  logic [N-1:0]    ld_match_vec;
  logic            ld_unresolved;
  logic [IDXW-1:0] ld_rot_amt;
  logic [IDXW-1:0] head_idx;

  sq_age_search #(.SQ_SIZE(N), .XLEN(XLEN)) dut (
    .clock         (clock),
    .reset         (reset),
    .disp_en       (disp_en),
    .disp_idx      (disp_idx),
    .full          (full),
    .empty         (empty),
    .ex_en         (ex_en),
    .ex_idx        (ex_idx),
    .ex_addr       (ex_addr),
    .ex_data       (ex_data),
    .ex_size       (ex_size),
    .commit_en     (commit_en),
    .head_ready    (head_ready),
    .mem_wr_valid  (mem_wr_valid),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_size   (mem_wr_size),
    .squash_en     (squash_en),
    .ld_en         (ld_en),
    .ld_addr       (ld_addr),
    .ld_tail       (ld_tail),
    .ld_match_vec  (ld_match_vec),
    .ld_unresolved (ld_unresolved),
    .ld_rot_amt    (ld_rot_amt),
    .head_idx      (head_idx)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_valid [N];
  bit            m_res   [N];
  logic [31:0]   m_addr  [N];
  logic [31:0]   m_data  [N];
  logic [1:0]    m_size  [N];
  int            m_head, m_tail, m_count;
  bit            m_wr_exp;
  bit            model_live = 1'b0;
  logic [W-1:0]  exp_q[$];

  always @(posedge clock) begin : model_step
    bit cm;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 0; m_res[i] = 0; m_addr[i] = '0; m_data[i] = '0; m_size[i] = '0;
      end
      m_head = 0; m_tail = 0; m_count = 0; m_wr_exp = 0;
      exp_q.delete();
      model_live = 1'b1;
    end else if (model_live) begin
      cm = commit_en && m_valid[m_head] && m_res[m_head];
      m_wr_exp = cm;
      if (cm) exp_q.push_back({m_addr[m_head], m_data[m_head], m_size[m_head]});
      if (squash_en) begin
        if (cm) m_head = (m_head + 1) % N;
        for (int i = 0; i < N; i++) begin
          m_valid[i] = 0; m_res[i] = 0;
        end
        m_tail = m_head; m_count = 0;
      end else begin
        if (ex_en && m_valid[ex_idx]) begin
          m_addr[ex_idx] = ex_addr; m_data[ex_idx] = ex_data;
          m_size[ex_idx] = ex_size; m_res[ex_idx] = 1;
        end
        if (disp_en && m_count < N) begin
          m_valid[m_tail] = 1; m_res[m_tail] = 0;
          m_tail = (m_tail + 1) % N; m_count++;
        end
        if (cm) begin
          m_valid[m_head] = 0; m_res[m_head] = 0;
          m_head = (m_head + 1) % N; m_count--;
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clock) begin : compare
    logic [W-1:0] w;
    logic [N-1:0] e_match;
    bit           e_unres;
    int           span, idx;
    if (model_live) begin
      chk("disp_idx", 64'(disp_idx), 64'(m_tail));
      chk("head_idx", 64'(head_idx), 64'(m_head));
      chk("full", 64'(full), 64'(m_count == N));
      chk("empty", 64'(empty), 64'(m_count == 0));
      chk("head_ready", 64'(head_ready), 64'(m_valid[m_head] && m_res[m_head]));
      chk("mem_wr_valid", 64'(mem_wr_valid), 64'(m_wr_exp));
      if (m_wr_exp) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_nonempty", 64'(0), 64'(1));
        end else begin
          w = exp_q.pop_front();
          chk("mem_wr_addr", 64'(mem_wr_addr), 64'(w[65:34]));
          chk("mem_wr_data", 64'(mem_wr_data), 64'(w[33:2]));
          chk("mem_wr_size", 64'(mem_wr_size), 64'(w[1:0]));
        end
      end
      if (ld_en) begin
        e_match = '0;
        e_unres = 0;
        span = (int'(ld_tail) - m_head + N) % N;
        for (int k = 0; k < span; k++) begin
          idx = (m_head + k) % N;
          if (m_valid[idx]) begin
            if (!m_res[idx]) e_unres = 1;
            else if (m_addr[idx][31:2] == ld_addr[31:2]) e_match[idx] = 1'b1;
          end
        end
        chk("ld_match_vec", 64'(ld_match_vec), 64'(e_match));
        chk("ld_unresolved", 64'(ld_unresolved), 64'(e_unres));
        chk("ld_rot_amt", 64'(ld_rot_amt), 64'((N - m_head) % N));
      end else begin
        chk("ld_match_idle", 64'(ld_match_vec), 64'(0));
        chk("ld_unres_idle", 64'(ld_unresolved), 64'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    disp_en = 0; ex_en = 0; ex_idx = '0; ex_addr = '0; ex_data = '0; ex_size = '0;
    commit_en = 0; squash_en = 0; ld_en = 0; ld_addr = '0; ld_tail = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    cyc(); cyc();
    reset = 0;
  endtask

  task automatic resolve(input int idx, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    ex_en = 1; ex_idx = IDXW'(idx); ex_addr = a; ex_data = d; ex_size = s;
    cyc();
    ex_en = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    do_reset();
    #1;
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_disp_idx", 64'(disp_idx), 64'(0));
    chk("rst_mem_wr_valid", 64'(mem_wr_valid), 64'(0));
    chk("rst_mem_wr_addr", 64'(mem_wr_addr), 64'(0));

    // Eight back-to-back dispatches, then one while full.
    disp_en = 1;
    for (int i = 0; i < N; i++) begin
      chk("fill_disp_idx", 64'(disp_idx), 64'(i));
      cyc();
    end
    chk("fill_full", 64'(full), 64'(1));
    $display("note: driving disp_en while full (protocol error, must be dropped)");
    cyc();
    disp_en = 0;
    chk("ovf_tail", 64'(disp_idx), 64'(0));
    chk("ovf_full", 64'(full), 64'(1));
    chk("model_count_full", 64'(m_count), 64'(8));

    // Resolve and retire entry 0.
    resolve(0, 32'h100, 32'hDEADBEEF, 2'd2);
    chk("head_ready_0", 64'(head_ready), 64'(1));
    commit_en = 1;
    cyc();
    commit_en = 0;
    chk("c0_valid", 64'(mem_wr_valid), 64'(1));
    chk("c0_addr", 64'(mem_wr_addr), 64'h100);
    chk("c0_data", 64'(mem_wr_data), 64'hDEADBEEF);
    chk("c0_size", 64'(mem_wr_size), 64'(2));
    chk("c0_head", 64'(head_idx), 64'(1));
    cyc();
    chk("c0_strobe_one_cycle", 64'(mem_wr_valid), 64'(0));

    // Refill to full, then dispatch + commit together.
    disp_en = 1; cyc(); disp_en = 0;
    chk("refull", 64'(full), 64'(1));
    resolve(1, 32'h200, 32'h11112222, 2'd1);
    disp_en = 1; commit_en = 1;
    cyc();
    disp_en = 0; commit_en = 0;
    chk("dc_full", 64'(full), 64'(0));
    chk("dc_tail", 64'(disp_idx), 64'(1));
    chk("dc_head", 64'(head_idx), 64'(2));
    chk("dc_wr", 64'(mem_wr_valid), 64'(1));
    chk("dc_addr", 64'(mem_wr_addr), 64'h200);
    chk("model_count_dc", 64'(m_count), 64'(7));

    // Three stores, squash together with commit.
    do_reset();
    disp_en = 1; cyc(); cyc(); cyc(); disp_en = 0;
    resolve(0, 32'h300, 32'hCAFE0001, 2'd0);
    squash_en = 1; commit_en = 1;
    cyc();
    squash_en = 0; commit_en = 0;
    chk("sq_empty", 64'(empty), 64'(1));
    chk("sq_head", 64'(head_idx), 64'(1));
    chk("sq_tail", 64'(disp_idx), 64'(1));
    chk("sq_wr", 64'(mem_wr_valid), 64'(1));
    chk("sq_wr_addr", 64'(mem_wr_addr), 64'h300);
    cyc();
    chk("sq_wr_once", 64'(mem_wr_valid), 64'(0));

    // Walk head to 6, then build entries 6,7,0.
    disp_en = 1;
    for (int i = 0; i < 5; i++) cyc();
    disp_en = 0;
    for (int i = 1; i <= 5; i++) resolve(i, 32'h500 + 32'(i), 32'(i), 2'd2);
    commit_en = 1;
    for (int i = 0; i < 5; i++) cyc();
    commit_en = 0;
    chk("walk_head", 64'(head_idx), 64'(6));
    disp_en = 1; cyc(); cyc(); cyc(); disp_en = 0;
    resolve(6, 32'h40, 32'hA6, 2'd2);
    resolve(0, 32'h40, 32'hA0, 2'd2);
    ld_en = 1; ld_addr = 32'h42; ld_tail = 3'd1;
    #1;
    chk("ld_part_match", 64'(ld_match_vec), 64'h41);
    chk("ld_part_unres", 64'(ld_unresolved), 64'(1));
    cyc();
    ld_en = 0;
    resolve(7, 32'h40, 32'hA7, 2'd2);
    ld_en = 1; ld_addr = 32'h42; ld_tail = 3'd1;
    #1;
    chk("ld_full_match", 64'(ld_match_vec), 64'hC1);
    chk("ld_full_unres", 64'(ld_unresolved), 64'(0));
    chk("ld_rot", 64'(ld_rot_amt), 64'(2));
    ld_tail = 3'd6;
    #1;
    chk("ld_empty_range", 64'(ld_match_vec), 64'(0));
    ld_en = 0;
    #1;
    chk("ld_idle", 64'(ld_match_vec), 64'(0));
    cyc();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      disp_en   = (m_count < N) && ($urandom_range(0, 1) == 1);
      ex_en     = ($urandom_range(0, 2) != 0);
      ex_idx    = IDXW'($urandom_range(0, N - 1));
      ex_addr   = 32'h40 + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 3));
      ex_data   = $urandom;
      ex_size   = 2'($urandom_range(0, 2));
      commit_en = ($urandom_range(0, 1) == 1);
      squash_en = ($urandom_range(0, 29) == 0);
      ld_en     = ($urandom_range(0, 3) != 0);
      ld_addr   = 32'h40 + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 3));
      ld_tail   = IDXW'($urandom_range(0, N - 1));
      cyc();
    end
    idle_inputs();
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
